// File: rtl/l_next_pkg.sv
// Shared definitions for the next-level port: command encodings and arbiter FSM states.
package l_next_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RWITM = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/l_next_arbiter.sv
// Round-robin arbiter sharing the next-level port between the L1 data (0) and instr (1) requesters.
module l_next_arbiter
    import l_next_pkg::*;
#(
    parameter int unsigned ADDR_W  = 26,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic [1:0]         cmd0,
    input  logic [1:0]         cmd1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [ADDR_W-1:0]  add_out,
    output logic [1:0]         cmd_out,
    output logic               busy,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] wr_count,
    output logic [COUNT_W-1:0] rwitm_count
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_e              state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic                last, last_n;
    logic                win, win_n;
    cmd_e                cmd_lat, cmd_lat_n;
    logic [ADDR_W-1:0]   add_n;
    logic [1:0]          cmd_out_n;
    logic                gnt0_n, gnt1_n, done0_n, done1_n, busy_n;
    logic                valid0, valid1, pick;
    logic                inc_rd, inc_wr, inc_rwitm;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last;
        win_n     = win;
        cmd_lat_n = cmd_lat;
        add_n     = add_out;
        cmd_out_n = cmd_out;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        busy_n    = busy;
        valid0    = req0 && (cmd0 != CMD_NOP);
        valid1    = req1 && (cmd1 != CMD_NOP);
        // Under contention the requester that did not win last time goes first.
        pick      = valid1 && (!valid0 || !last);

        unique case (state)
            ST_IDLE: begin
                if (valid0 || valid1) begin
                    win_n     = pick;
                    if (valid0 && valid1) begin
                        last_n = pick;
                    end
                    add_n     = pick ? addr1 : addr0;
                    cmd_out_n = pick ? cmd1 : cmd0;
                    cmd_lat_n = cmd_e'(pick ? cmd1 : cmd0);
                    cnt_n     = CNT_LOAD;
                    gnt0_n    = !pick;
                    gnt1_n    = pick;
                    busy_n    = 1'b1;
                    state_n   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 8'd0) begin
                    cmd_out_n = CMD_NOP;
                    done0_n   = !win;
                    done1_n   = win;
                    state_n   = ST_RESP;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            ST_RESP: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            win     <= 1'b0;
            cmd_lat <= CMD_NOP;
            add_out <= '0;
            cmd_out <= CMD_NOP;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            last    <= last_n;
            win     <= win_n;
            cmd_lat <= cmd_lat_n;
            add_out <= add_n;
            cmd_out <= cmd_out_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            done0   <= done0_n;
            done1   <= done1_n;
            busy    <= busy_n;
        end
    end

    assign inc_rd    = (state == ST_RESP) && (cmd_lat == CMD_READ);
    assign inc_wr    = (state == ST_RESP) && (cmd_lat == CMD_WRITE);
    assign inc_rwitm = (state == ST_RESP) && (cmd_lat == CMD_RWITM);

    sat_counter #(.COUNT_W(COUNT_W)) u_rd_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_rd),
        .count (rd_count)
    );

    sat_counter #(.COUNT_W(COUNT_W)) u_wr_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_wr),
        .count (wr_count)
    );

    sat_counter #(.COUNT_W(COUNT_W)) u_rwitm_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_rwitm),
        .count (rwitm_count)
    );

endmodule
